hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter DATA_W, default 16, data width.
REQ-002 Parameter ADDR_W, default 4, register address width.
REQ-003 Parameter NUM_RD, default 2, number of operand read ports.
REQ-004 Parameter CNT_W, default 2, width of the per-register pending-load counter.
REQ-005 Parameter STALL_MAX, default 15, consecutive-stall watchdog limit.
REQ-006 Parameter ZERO_REG, default 1; when 1, register 0 is hardwired zero and never forwarded or tracked.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-008 Ports, as name direction width meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- rd_en  in  NUM_RD  per-port operand valid.
- rd_addr  in  NUM_RD*ADDR_W  per-port source register, packed, port 0 in LSBs.
- rf_data  in  NUM_RD*DATA_W  per-port register-file read value.
- exm_we, exm_is_load  in  1 each  EX/MEM writes a register / is a load.
- exm_addr  in  ADDR_W  EX/MEM destination.
- exm_result  in  DATA_W  EX/MEM ALU or link value.
- mwb_we  in  1  MEM/WB writes a register.
- mwb_addr  in  ADDR_W  MEM/WB destination.
- mwb_result  in  DATA_W  final MEM/WB writeback value.
- ld_issue  in  1  load leaves EX/MEM into memory this cycle.
- ld_issue_addr  in  ADDR_W  destination of the issuing load.
- ld_done  in  1  oldest outstanding load returns this cycle; memory returns in order.
- ld_done_addr  in  ADDR_W  destination of the returning load.
- ld_done_data  in  DATA_W  returned load data.
- flush  in  1  kill the consumer instruction.
- fwd_data  out  NUM_RD*DATA_W  forwarded operands.
- fwd_src  out  NUM_RD*3  per-port source: 0 rf, 1 zero, 2 ld_done, 3 exm, 4 mwb.
- stall  out  1  hold the consumer instruction.
- hang_err, ovf_err  out  1 each  sticky watchdog / counter-overflow errors.

Function
REQ-009 Each port SHALL select, in priority order: (a) ZERO_REG=1 and addr=0 -> zero data, src 1; (b) ld_done and ld_done_addr=addr and pending count=1 -> ld_done_data, src 2; (c) exm_we and exm_addr=addr and !exm_is_load -> exm_result, src 3; (d) mwb_we and mwb_addr=addr -> mwb_result, src 4; (e) otherwise rf_data, src 0.
REQ-010 Operand selection SHALL be combinational, with zero-cycle latency.
REQ-011 The block SHALL keep one CNT_W-bit pending counter per register, excluding register 0 when ZERO_REG=1.
REQ-012 On ld_issue the counter of ld_issue_addr SHALL increment at the clock edge.
REQ-013 On ld_done the counter of ld_done_addr SHALL decrement at the clock edge.
REQ-014 If ld_issue and ld_done target the same register in one cycle, its counter SHALL stay unchanged.
REQ-015 On an increment at the maximum count, the counter SHALL hold and ovf_err SHALL set.
REQ-016 On ld_done with a zero count, the counter SHALL hold at 0 and ovf_err SHALL set.
REQ-017 A port SHALL request a stall when rd_en=1, the register is tracked, and any of: count>=2; count=1 with no matching ld_done; exm_we and exm_is_load and exm_addr=addr.
REQ-018 stall SHALL be the OR of all port requests, gated low while flush=1.
REQ-019 A register with rd_en=0 SHALL never cause a stall.
REQ-020 flush SHALL NOT alter any pending counter; outstanding loads still retire.
REQ-021 A run counter SHALL increment each cycle stall=1 and clear when stall=0 or flush=1.
REQ-022 When the run counter reaches STALL_MAX, hang_err SHALL set; the counter SHALL saturate.
REQ-023 hang_err and ovf_err SHALL be sticky until reset.

Reset
REQ-024 While rst_n=0: all pending counters 0, run counter 0, hang_err=0, ovf_err=0; stall reflects only EX/MEM load matches (REQ-017).
REQ-025 Reset asserted mid-operation SHALL discard all outstanding-load tracking immediately, without waiting for a clock edge.

Verification
REQ-026 The bench SHALL cover: exm_we=1, exm_addr=3, exm_result=0x1234, mwb_we=1, mwb_addr=3, mwb_result=0xBEEF, port0 addr 3 -> fwd_data0=0x1234, src 3, stall=0.
REQ-027 The bench SHALL cover: exm load to r5, port1 reads r5 -> stall=1; next cycle ld_issue r5 -> count 1, stall held; ld_done r5 data 0x00AA -> fwd_data1=0x00AA, src 2, stall=0 same cycle.
REQ-028 The bench SHALL cover: two loads issued to r7 -> count 2; first ld_done r7 -> stall remains 1; second ld_done -> forwarded, stall=0, count 0.
REQ-029 The bench SHALL cover: ZERO_REG=1, port0 addr 0, exm_we=1, exm_addr=0 -> fwd_data0=0, src 1, no stall; ZERO_REG=0 -> src 3.
REQ-030 The bench SHALL cover: pending r2 never returned, rd_en0=1 -> hang_err=1 after 15 stall cycles; flush=1 -> stall=0, run counter 0, hang_err stays 1.
REQ-031 The bench SHALL cover: 4 ld_issue to r4 with CNT_W=2 -> ovf_err=1, count 3; rst_n pulsed low asynchronously -> counters 0, ovf_err=0 before the next edge.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Operand forwarding and load-use hazard unit.
// Each read port picks its operand from the highest-priority in-flight
// producer. One pending-load counter per register lets a consumer wait for
// outstanding loads. A run counter watches for stalls that never end.
module hazard_forward_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int CNT_W     = 2,
  parameter int STALL_MAX = 15,
  parameter int ZERO_REG  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  input  logic                     exm_we,
  input  logic                     exm_is_load,
  input  logic [ADDR_W-1:0]        exm_addr,
  input  logic [DATA_W-1:0]        exm_result,
  input  logic                     mwb_we,
  input  logic [ADDR_W-1:0]        mwb_addr,
  input  logic [DATA_W-1:0]        mwb_result,
  input  logic                     ld_issue,
  input  logic [ADDR_W-1:0]        ld_issue_addr,
  input  logic                     ld_done,
  input  logic [ADDR_W-1:0]        ld_done_addr,
  input  logic [DATA_W-1:0]        ld_done_data,
  input  logic                     flush,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [NUM_RD*3-1:0]      fwd_src,
  output logic                     stall,
  output logic                     hang_err,
  output logic                     ovf_err
);

  localparam int NUM_REG = 1 << ADDR_W;
  localparam int RUN_W   = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_MAX);

  typedef enum logic [2:0] {
    SRC_RF   = 3'd0,
    SRC_ZERO = 3'd1,
    SRC_LD   = 3'd2,
    SRC_EXM  = 3'd3,
    SRC_MWB  = 3'd4
  } src_e;

  logic [CNT_W-1:0] r_pend_cnt [NUM_REG];
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_hang_err;
  logic             r_ovf_err;

  logic [NUM_RD-1:0] w_port_stall;
  logic              w_inc_vld;
  logic              w_dec_vld;
  logic              w_same;
  logic              w_ovf;
  logic [RUN_W-1:0]  w_run_next;

  // Register 0 is hardwired zero when ZERO_REG is set, so it is never tracked.
  function automatic logic is_tracked(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_trk;
    logic              w_ld_hit;
    logic              w_exm_ld_hit;
    logic [DATA_W-1:0] w_data;
    src_e              w_src;

    assign w_addr       = rd_addr[p*ADDR_W +: ADDR_W];
    assign w_cnt        = r_pend_cnt[w_addr];
    assign w_trk        = is_tracked(w_addr);
    assign w_ld_hit     = ld_done && (ld_done_addr == w_addr);
    assign w_exm_ld_hit = exm_we && exm_is_load && (exm_addr == w_addr);

    // Priority operand mux: zero reg, returning load, EX/MEM, MEM/WB, regfile.
    always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      w_src  = SRC_RF;
      w_data = rf_data[p*DATA_W +: DATA_W];
      if (!w_trk) begin
        w_src  = SRC_ZERO;
        w_data = '0;
      end else if (w_ld_hit && (w_cnt == CNT_ONE)) begin
        w_src  = SRC_LD;
        w_data = ld_done_data;
      end else if (exm_we && (exm_addr == w_addr) && !exm_is_load) begin
        w_src  = SRC_EXM;
        w_data = exm_result;
      end else if (mwb_we && (mwb_addr == w_addr)) begin
        w_src  = SRC_MWB;
        w_data = mwb_result;
      end
    end

    assign fwd_data[p*DATA_W +: DATA_W] = w_data;
    assign fwd_src[p*3 +: 3]            = w_src;

    // The last outstanding load can be consumed the cycle it returns; older
    // ones, or a load still sitting in EX/MEM, force a wait.
    assign w_port_stall[p] = rd_en[p] && w_trk &&
                             ((w_cnt > CNT_ONE) ||
                              ((w_cnt == CNT_ONE) && !w_ld_hit) ||
                              w_exm_ld_hit);
  end

  assign stall = (|w_port_stall) && !flush;

  // A load issuing and retiring to the same register cancels out.
  assign w_inc_vld = ld_issue && is_tracked(ld_issue_addr);
  assign w_dec_vld = ld_done && is_tracked(ld_done_addr);
  assign w_same    = w_inc_vld && w_dec_vld && (ld_issue_addr == ld_done_addr);
  assign w_ovf     = (w_inc_vld && !w_same && (r_pend_cnt[ld_issue_addr] == CNT_MAX)) ||
                     (w_dec_vld && !w_same && (r_pend_cnt[ld_done_addr] == '0));

  // Pending-load counters, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose: reset must cancel every
      // outstanding load at once, so it cannot be left as plain RAM.
      for (int r = 0; r < NUM_REG; r++) begin
        r_pend_cnt[r] <= '0;
      end
    end else begin
      if (w_inc_vld && !w_same && (r_pend_cnt[ld_issue_addr] != CNT_MAX)) begin
        r_pend_cnt[ld_issue_addr] <= r_pend_cnt[ld_issue_addr] + CNT_ONE;
      end
      if (w_dec_vld && !w_same && (r_pend_cnt[ld_done_addr] != '0)) begin
        r_pend_cnt[ld_done_addr] <= r_pend_cnt[ld_done_addr] - CNT_ONE;
      end
    end
  end

  // Consecutive-stall run length, saturating at STALL_MAX.
  assign w_run_next = !stall ? '0 :
                      (r_run_cnt == RUN_MAX) ? r_run_cnt : r_run_cnt + RUN_W'(1);

  // Run counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt  <= '0;
      r_hang_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      r_run_cnt  <= w_run_next;
      r_hang_err <= r_hang_err || (w_run_next == RUN_MAX);
      r_ovf_err  <= r_ovf_err || w_ovf;
    end
  end

  assign hang_err = r_hang_err;
  assign ovf_err  = r_ovf_err;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus a
// randomized run compared against a counter-per-register reference model.
module tb_hazard_forward_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rf_data;
  logic                     exm_we, exm_is_load;
  logic [ADDR_W-1:0]        exm_addr;
  logic [DATA_W-1:0]        exm_result;
  logic                     mwb_we;
  logic [ADDR_W-1:0]        mwb_addr;
  logic [DATA_W-1:0]        mwb_result;
  logic                     ld_issue;
  logic [ADDR_W-1:0]        ld_issue_addr;
  logic                     ld_done;
  logic [ADDR_W-1:0]        ld_done_addr;
  logic [DATA_W-1:0]        ld_done_data;
  logic                     flush;
  logic [NUM_RD*DATA_W-1:0] fwd_data;
  logic [NUM_RD*3-1:0]      fwd_src;
  logic                     stall, hang_err, ovf_err;
  logic [NUM_RD*DATA_W-1:0] nz_fwd_data;
  logic [NUM_RD*3-1:0]      nz_fwd_src;
  logic                     nz_stall, nz_hang_err, nz_ovf_err;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
    .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_addr(exm_addr), .exm_result(exm_result),
    .mwb_we(mwb_we), .mwb_addr(mwb_addr), .mwb_result(mwb_result),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_done(ld_done), .ld_done_addr(ld_done_addr), .ld_done_data(ld_done_data),
    .flush(flush), .fwd_data(fwd_data), .fwd_src(fwd_src), .stall(stall),
    .hang_err(hang_err), .ovf_err(ovf_err)
  );

  hazard_forward_unit #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
    .exm_we(exm_we), .exm_is_load(exm_is_load), .exm_addr(exm_addr), .exm_result(exm_result),
    .mwb_we(mwb_we), .mwb_addr(mwb_addr), .mwb_result(mwb_result),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .ld_done(ld_done), .ld_done_addr(ld_done_addr), .ld_done_data(ld_done_data),
    .flush(flush), .fwd_data(nz_fwd_data), .fwd_src(nz_fwd_src), .stall(nz_stall),
    .hang_err(nz_hang_err), .ovf_err(nz_ovf_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: outstanding-load count per register, sticky flags,
  // and the length of the current stall run.
  int m_cnt [16];
  bit m_ovf, m_hang;
  int m_run;

  function automatic void m_clear();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_ovf = 0; m_hang = 0; m_run = 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    int a;
    s = 0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
      if (rd_en[p] && a != 0) begin
        if (m_cnt[a] >= 2) s = 1;
        if (m_cnt[a] == 1 && !(ld_done && int'(ld_done_addr) == a)) s = 1;
        if (exm_we && exm_is_load && int'(exm_addr) == a) s = 1;
      end
    end
    return s && !flush;
  endfunction

  function automatic void m_fwd(input int p, output logic [DATA_W-1:0] d, output logic [2:0] s);
    int a;
    a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
    if (a == 0) begin
      d = '0; s = 3'd1;
    end else if (ld_done && int'(ld_done_addr) == a && m_cnt[a] == 1) begin
      d = ld_done_data; s = 3'd2;
    end else if (exm_we && !exm_is_load && int'(exm_addr) == a) begin
      d = exm_result; s = 3'd3;
    end else if (mwb_we && int'(mwb_addr) == a) begin
      d = mwb_result; s = 3'd4;
    end else begin
      d = rf_data[p*DATA_W +: DATA_W]; s = 3'd0;
    end
  endfunction

  // One clock edge, with the model advanced by the same rules; leaves time
  // 1 unit after the edge so new stimulus is applied away from the edge.
  task automatic tick();
    bit s, iv, dv;
    int ia, da;
    s  = m_stall();
    ia = int'(ld_issue_addr);
    da = int'(ld_done_addr);
    iv = ld_issue && ia != 0;
    dv = ld_done && da != 0;
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else begin
      if (!(iv && dv && ia == da)) begin
        if (iv) begin
          if (m_cnt[ia] == 3) m_ovf = 1; else m_cnt[ia]++;
        end
        if (dv) begin
          if (m_cnt[da] == 0) m_ovf = 1; else m_cnt[da]--;
        end
      end
      m_run = s ? ((m_run < 15) ? m_run + 1 : 15) : 0;
      if (m_run == 15) m_hang = 1;
    end
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; rf_data = '0;
    exm_we = 0; exm_is_load = 0; exm_addr = '0; exm_result = '0;
    mwb_we = 0; mwb_addr = '0; mwb_result = '0;
    ld_issue = 0; ld_issue_addr = '0; ld_done = 0; ld_done_addr = '0; ld_done_data = '0;
    flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    m_clear();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m_clear();
    exm_we = 1; exm_is_load = 1; exm_addr = 4'd5;
    rd_en = 2'b10; rd_addr = {4'd5, 4'd0};
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL reset_exm_load_stall: got %b want 1", stall); else n_pass++;
    n_total++; if (hang_err !== 1'b0) $display("FAIL reset_hang: got %b want 0", hang_err); else n_pass++;
    n_total++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_err); else n_pass++;
    n_total++; if (dut.r_pend_cnt[5] !== 2'd0) $display("FAIL reset_cnt: got %0d want 0", dut.r_pend_cnt[5]); else n_pass++;
    exm_is_load = 0; exm_result = 16'h7777;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_nonload_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (fwd_data[31:16] !== 16'h7777 || fwd_src[5:3] !== 3'd3)
      $display("FAIL reset_fwd: got %h/%0d want 7777/3", fwd_data[31:16], fwd_src[5:3]); else n_pass++;
    idle();
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_exm_priority();
    idle();
    exm_we = 1; exm_addr = 4'd3; exm_result = 16'h1234;
    mwb_we = 1; mwb_addr = 4'd3; mwb_result = 16'hBEEF;
    rf_data = {16'h0, 16'hCAFE};
    rd_en = 2'b01; rd_addr = {4'd0, 4'd3};
    #1;
    n_total++; if (fwd_data[15:0] !== 16'h1234 || fwd_src[2:0] !== 3'd3)
      $display("FAIL exm_fwd: got %h/%0d want 1234/3", fwd_data[15:0], fwd_src[2:0]); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL exm_stall: got %b want 0", stall); else n_pass++;
    exm_we = 0;
    #1;
    n_total++; if (fwd_data[15:0] !== 16'hBEEF || fwd_src[2:0] !== 3'd4)
      $display("FAIL mwb_fwd: got %h/%0d want beef/4", fwd_data[15:0], fwd_src[2:0]); else n_pass++;
    mwb_we = 0;
    #1;
    n_total++; if (fwd_data[15:0] !== 16'hCAFE || fwd_src[2:0] !== 3'd0)
      $display("FAIL rf_fwd: got %h/%0d want cafe/0", fwd_data[15:0], fwd_src[2:0]); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    exm_we = 1; exm_is_load = 1; exm_addr = 4'd5;
    rd_en = 2'b00; rd_addr = {4'd5, 4'd0};
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL ld_use_rd_en0: got %b want 0", stall); else n_pass++;
    rd_en = 2'b10;
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL ld_use_exm_stall: got %b want 1", stall); else n_pass++;
    tick();
    ld_issue = 1; ld_issue_addr = 4'd5;
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL ld_use_issue_stall: got %b want 1", stall); else n_pass++;
    tick();
    ld_issue = 0; exm_we = 0; exm_is_load = 0;
    #1;
    n_total++; if (dut.r_pend_cnt[5] !== 2'd1) $display("FAIL ld_use_cnt1: got %0d want 1", dut.r_pend_cnt[5]); else n_pass++;
    n_total++; if (stall !== 1'b1) $display("FAIL ld_use_pending_stall: got %b want 1", stall); else n_pass++;
    tick();
    ld_done = 1; ld_done_addr = 4'd5; ld_done_data = 16'h00AA;
    #1;
    n_total++; if (fwd_data[31:16] !== 16'h00AA || fwd_src[5:3] !== 3'd2)
      $display("FAIL ld_use_fwd: got %h/%0d want 00aa/2", fwd_data[31:16], fwd_src[5:3]); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL ld_use_release: got %b want 0", stall); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (dut.r_pend_cnt[5] !== 2'd0) $display("FAIL ld_use_cnt0: got %0d want 0", dut.r_pend_cnt[5]); else n_pass++;
  endtask

  task automatic test_multi_load();
    idle();
    ld_issue = 1; ld_issue_addr = 4'd7;
    tick();
    tick();
    ld_issue = 0;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
    #1;
    n_total++; if (dut.r_pend_cnt[7] !== 2'd2) $display("FAIL multi_cnt2: got %0d want 2", dut.r_pend_cnt[7]); else n_pass++;
    ld_done = 1; ld_done_addr = 4'd7; ld_done_data = 16'h1111;
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL multi_first_done_stall: got %b want 1", stall); else n_pass++;
    n_total++; if (fwd_src[2:0] === 3'd2) $display("FAIL multi_first_done_src: got %0d want not 2", fwd_src[2:0]); else n_pass++;
    tick();
    ld_done_data = 16'h2222;
    #1;
    n_total++; if (fwd_data[15:0] !== 16'h2222 || fwd_src[2:0] !== 3'd2)
      $display("FAIL multi_second_fwd: got %h/%0d want 2222/2", fwd_data[15:0], fwd_src[2:0]); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL multi_second_stall: got %b want 0", stall); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (dut.r_pend_cnt[7] !== 2'd0) $display("FAIL multi_cnt0: got %0d want 0", dut.r_pend_cnt[7]); else n_pass++;
  endtask

  task automatic test_zero_reg();
    idle();
    exm_we = 1; exm_addr = 4'd0; exm_result = 16'h5555;
    rd_en = 2'b01; rd_addr = 8'h00;
    #1;
    n_total++; if (fwd_data[15:0] !== 16'h0000 || fwd_src[2:0] !== 3'd1)
      $display("FAIL zero_fwd: got %h/%0d want 0000/1", fwd_data[15:0], fwd_src[2:0]); else n_pass++;
    n_total++; if (nz_fwd_data[15:0] !== 16'h5555 || nz_fwd_src[2:0] !== 3'd3)
      $display("FAIL nozero_fwd: got %h/%0d want 5555/3", nz_fwd_data[15:0], nz_fwd_src[2:0]); else n_pass++;
    exm_is_load = 1;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL zero_no_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (nz_stall !== 1'b1) $display("FAIL nozero_stall: got %b want 1", nz_stall); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_hang();
    do_reset();
    ld_issue = 1; ld_issue_addr = 4'd2;
    tick();
    ld_issue = 0;
    rd_en = 2'b01; rd_addr = {4'd0, 4'd2};
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL hang_stall: got %b want 1", stall); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 14) begin
        n_total++; if (hang_err !== 1'b0) $display("FAIL hang_early: got %b want 0", hang_err); else n_pass++;
      end
      if (i == 15) begin
        n_total++; if (hang_err !== 1'b1) $display("FAIL hang_set: got %b want 1", hang_err); else n_pass++;
      end
    end
    n_total++; if (dut.r_run_cnt !== 4'd15) $display("FAIL hang_run_sat: got %0d want 15", dut.r_run_cnt); else n_pass++;
    flush = 1;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL hang_flush_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_total++; if (dut.r_run_cnt !== 4'd0) $display("FAIL hang_flush_run: got %0d want 0", dut.r_run_cnt); else n_pass++;
    n_total++; if (hang_err !== 1'b1) $display("FAIL hang_sticky: got %b want 1", hang_err); else n_pass++;
    n_total++; if (dut.r_pend_cnt[2] !== 2'd1) $display("FAIL hang_flush_cnt: got %0d want 1", dut.r_pend_cnt[2]); else n_pass++;
    flush = 0;
    ld_done = 1; ld_done_addr = 4'd2; ld_done_data = 16'h0F0F;
    #1;
    n_total++; if (fwd_data[15:0] !== 16'h0F0F || stall !== 1'b0)
      $display("FAIL hang_retire: got %h/%b want 0f0f/0", fwd_data[15:0], stall); else n_pass++;
    tick();
    idle();
  endtask

  task automatic test_overflow();
    do_reset();
    ld_issue = 1; ld_issue_addr = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) begin
        n_total++; if (ovf_err !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf_err); else n_pass++;
      end
    end
    ld_issue = 0;
    n_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf_err); else n_pass++;
    n_total++; if (dut.r_pend_cnt[4] !== 2'd3) $display("FAIL ovf_cnt_sat: got %0d want 3", dut.r_pend_cnt[4]); else n_pass++;
    #2;
    rst_n = 0;
    m_clear();
    #1;
    n_total++; if (dut.r_pend_cnt[4] !== 2'd0) $display("FAIL async_rst_cnt: got %0d want 0", dut.r_pend_cnt[4]); else n_pass++;
    n_total++; if (ovf_err !== 1'b0) $display("FAIL async_rst_ovf: got %b want 0", ovf_err); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ld_issue = 1; ld_issue_addr = 4'd9;
    tick();
    ld_done = 1; ld_done_addr = 4'd9;
    tick();
    n_total++; if (dut.r_pend_cnt[9] !== 2'd1 || ovf_err !== 1'b0)
      $display("FAIL same_cycle: got %0d/%b want 1/0", dut.r_pend_cnt[9], ovf_err); else n_pass++;
    ld_issue_addr = 4'd10;
    tick();
    n_total++; if (dut.r_pend_cnt[9] !== 2'd0 || dut.r_pend_cnt[10] !== 2'd1)
      $display("FAIL split_cycle: got %0d/%0d want 0/1", dut.r_pend_cnt[9], dut.r_pend_cnt[10]); else n_pass++;
    ld_issue = 0; ld_done_addr = 4'd6;
    tick();
    n_total++; if (dut.r_pend_cnt[6] !== 2'd0 || ovf_err !== 1'b1)
      $display("FAIL underflow: got %0d/%b want 0/1", dut.r_pend_cnt[6], ovf_err); else n_pass++;
    idle();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] ed;
    logic [2:0]        es;
    bit                est;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rd_en         = 2'($urandom_range(0, 3));
      rd_addr       = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      rf_data       = {16'($urandom), 16'($urandom)};
      exm_we        = 1'($urandom_range(0, 1));
      exm_is_load   = ($urandom_range(0, 3) == 0);
      exm_addr      = 4'($urandom_range(0, 7));
      exm_result    = 16'($urandom);
      mwb_we        = 1'($urandom_range(0, 1));
      mwb_addr      = 4'($urandom_range(0, 7));
      mwb_result    = 16'($urandom);
      ld_issue      = ($urandom_range(0, 3) == 0);
      ld_issue_addr = 4'($urandom_range(0, 7));
      ld_done       = ($urandom_range(0, 3) == 0);
      ld_done_addr  = 4'($urandom_range(0, 7));
      ld_done_data  = 16'($urandom);
      flush         = ($urandom_range(0, 7) == 0);
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        m_fwd(p, ed, es);
        n_total++; if (fwd_data[p*DATA_W +: DATA_W] !== ed || fwd_src[p*3 +: 3] !== es)
          $display("FAIL rand_fwd c%0d p%0d: got %h/%0d want %h/%0d", c, p,
                   fwd_data[p*DATA_W +: DATA_W], fwd_src[p*3 +: 3], ed, es); else n_pass++;
      end
      est = m_stall();
      n_total++; if (stall !== est) $display("FAIL rand_stall c%0d: got %b want %b", c, stall, est); else n_pass++;
      n_total++; if (hang_err !== m_hang || ovf_err !== m_ovf)
        $display("FAIL rand_err c%0d: got %b%b want %b%b", c, hang_err, ovf_err, m_hang, m_ovf); else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_exm_priority();
    test_load_use();
    test_multi_load();
    test_zero_reg();
    test_hang();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
